// File: rtl/midi_tx.sv
// midi_tx: 8N1 serial MIDI transmitter with a one-byte holding register in front
// of the shifter, so consecutive bytes go out back-to-back without idle gaps.
module midi_tx #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int BAUD         = 31250,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD
) (
  input  logic       clk_i,
  input  logic       nrst_i,
  input  logic [7:0] txData_i,
  input  logic       txValid_i,
  output logic       txReady_o,
  output logic       txData_o,
  output logic       busy_o,
  output logic       txDone_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bitIdx_q, bitIdx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       hold_q, hold_d;
  logic             holdFull_q, holdFull_d;
  logic             txData_q, txData_d;

  logic bitEnd;
  logic load;
  logic accept;

  // Shared decodes: end of the current bit period, shifter load, and handshake.
  // load requires a full holding register and accept an empty one, so both
  // can never fire on the same edge.
  assign bitEnd = (cnt_q == CNT_LAST);
  assign load   = holdFull_q && ((state_q == S_IDLE) || ((state_q == S_STOP) && bitEnd));
  assign accept = txValid_i && !holdFull_q;

  // State and datapath registers; reset abandons any frame and idles the line.
  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      txData_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      txData_q   <= txData_d;
    end
  end

  // Next-state logic: START -> DATA x8 -> STOP, chaining straight into START if
  // a byte is already waiting in the holding register.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (load) state_d = S_START;
      S_START: if (bitEnd) state_d = S_DATA;
      S_DATA:  if (bitEnd && (bitIdx_q == 3'd7)) state_d = S_STOP;
      S_STOP:  if (bitEnd) state_d = load ? S_START : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Baud counter, bit index, shifter and holding register updates.
  always_comb begin
    cnt_d      = cnt_q;
    bitIdx_d   = bitIdx_q;
    shift_d    = shift_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;

    if ((state_q == S_IDLE) || bitEnd) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (load || ((state_q == S_START) && bitEnd)) begin
      bitIdx_d = '0;
    end else if ((state_q == S_DATA) && bitEnd && (bitIdx_q != 3'd7)) begin
      bitIdx_d = bitIdx_q + 3'd1;
    end

    if (load) begin
      shift_d    = hold_q;
      holdFull_d = 1'b0;
    end

    if (accept) begin
      hold_d     = txData_i;
      holdFull_d = 1'b1;
    end
  end

  // Output logic: serial level is registered one cycle behind the state.
  always_comb begin
    txData_d = 1'b1;
    unique case (state_q)
      S_START: txData_d = 1'b0;
      S_DATA:  txData_d = shift_q[bitIdx_q];
      default: txData_d = 1'b1;
    endcase
  end

  assign txData_o  = txData_q;
  assign txReady_o = !holdFull_q;
  assign busy_o    = (state_q != S_IDLE);
  assign txDone_o  = (state_q == S_STOP) && bitEnd;

endmodule

// File: doc/midi_tx.md
# midi_tx

Serial MIDI transmitter: takes bytes over a valid/ready handshake and shifts them out as 8N1 UART frames at the MIDI rate (31250 baud, LSB first, idle high). It is the transmit counterpart of the synth's MIDI receiver. It serves as a MIDI-thru/out port, and the verification bench uses it to drive the receiver input. A one-byte holding register sits in front of the shifter, so a full three-byte MIDI message streams with no idle gap between frames.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 31250: serial bit rate.
- CLKS_PER_BIT, CLK_FREQ/BAUD (integer division, 1600 at defaults): cycles per bit. Must be ≥ 2.
- clk_i  in  1  system clock; all logic on the rising edge.
- nrst_i  in  1  asynchronous active-low reset.
- txData_i  in  8  byte to send; sampled only on handshake.
- txValid_i  in  1  txData_i holds a byte to send.
- txReady_o  out  1  holding register empty; a byte is accepted when txValid_i && txReady_o at a rising edge.
- txData_o  out  1  serial output, registered; idle high.
- busy_o  out  1  a frame is in progress (state ≠ IDLE).
- txDone_o  out  1  one-cycle strobe in the last cycle of each stop bit.

## Operation
- Holding register `hold[7:0]` with flag `holdFull`. txReady_o = !holdFull (registered, no combinational path from txValid_i).
- Handshake: on an edge where txValid_i && txReady_o, capture hold ← txData_i and set holdFull.
- Shifter load: when the FSM is in IDLE, or in the final cycle of STOP, with holdFull = 1:
  - shift ← hold;
  - clear holdFull;
  - go to START.
- If an accept and a load could occur in the same cycle, the load clears the old contents first. This cannot happen, because accept requires holdFull = 0 and load requires holdFull = 1.
- FSM states:
  - IDLE: txData_o = 1. Go to START on load.
  - START: txData_o = 0 for CLKS_PER_BIT cycles, then go to DATA with bitIdx = 0.
  - DATA: txData_o = shift[bitIdx] for CLKS_PER_BIT cycles per bit. bitIdx increments 0..7. After bit 7, go to STOP.
  - STOP: txData_o = 1 for CLKS_PER_BIT cycles. In the last cycle, assert txDone_o. Then go to START if holdFull, otherwise go to IDLE.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 and wraps to 0 on every state or bit transition.
  - Held at 0 in IDLE.
  - No fractional-baud accumulation.
- bitIdx is 3 bits and saturates at 7. It never wraps within a frame.
- Reset (asynchronous, any time including mid-frame):
  - state = IDLE, txData_o = 1, txReady_o = 1, busy_o = 0, txDone_o = 0.
  - holdFull = 0, counters = 0.
  - Any partial frame is abandoned, and the line returns high immediately.
- txData_i is ignored while txValid_i is low or txReady_o is low.

## Timing
- Accept at edge N with the FSM idle: holdFull = 1 after edge N, load at edge N+1, txData_o = 0 from edge N+2. First-byte latency from accept to the start bit is 2 cycles.
- A frame is exactly 10×CLKS_PER_BIT cycles (16000 at defaults).
- Back-to-back: when holdFull is set before the final STOP cycle, the next start bit begins on the cycle right after the last stop-bit cycle, with zero idle cycles.
- txReady_o rises one cycle after the load edge (hold consumed). It can therefore accept the next byte while the current frame is still shifting.
- busy_o goes high with the START state and low one cycle after the final STOP cycle when nothing is pending.
- txDone_o is high exactly 1 cycle per frame, coincident with the last STOP cycle.

## Test plan
- Reset: hold nrst_i low with txValid_i = 1 → txData_o = 1, txReady_o = 1, busy_o = 0, txDone_o = 0. Release reset → no frame starts without a handshake in which txReady_o was 1 after reset.
- Single byte, CLK_FREQ = 312_500 (CLKS_PER_BIT = 10): send 0x90 → line reads 0 (start), then 0,0,0,0,1,0,0,1 (LSB first), then 1 (stop), each level held for 10 cycles. txDone_o pulses once at cycle 100 of the frame. busy_o then drops.
- Three-byte message 0x90, 0x3C, 0x64, with txValid_i held high → 3 contiguous frames (300 cycles) with no idle cycle between stop and start. txReady_o is low while hold is full. The receiver instance decodes exactly 0x90, 0x3C, 0x64.
- Backpressure: present 0x80 while hold is full; change txData_i to 0x7F before txReady_o rises → only the value present at the accepting edge (0x7F) is transmitted. No byte is dropped or duplicated.
- Reset mid-frame: assert nrst_i during DATA bit 3 → txData_o = 1 in the same cycle (asynchronous). After release, send 0x55 → a clean frame with no residue of the abandoned byte.
- Default parameters: send 0xF8 → bit period measured at 1600 cycles, frame at 16000 cycles.
